// File: rtl/mac_accum_4bit_pkg.sv
// Shared definitions for the 4-bit multiply-accumulate block:
// the FSM state encoding, the product width and the default accumulator width.
package mac_accum_4bit_pkg;

    localparam int PROD_W    = 8;
    localparam int ACC_W_DEF = 12;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/mac_accum_4bit_mult.sv
// 4x4 unsigned array multiplier: one AND row per multiplier bit,
// each row shifted into place and summed down the array.
module top_a1_q2_array_multi_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [7:0] p_o
);

    logic [3:0] pp [4];

    // Partial-product rows and their shifted ripple summation.
    always_comb begin
        p_o = 8'd0;
        for (int j = 0; j < 4; j++) begin
            pp[j] = a_i & {4{b_i[j]}};
            p_o   = p_o + ({4'd0, pp[j]} << j);
        end
    end

endmodule

// File: rtl/mac_accum_4bit.sv
// Multiply-accumulate of N_TERMS unsigned 4x4 products.
// Stage 1 captures the operand pair, stage 2 adds the product into acc.
// The result is held in HOLD until downstream consumes it.
module mac_accum_4bit
    import mac_accum_4bit_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] Acc_out,
    output logic             busy
);

    localparam logic [4:0] N_LAST = 5'(N_TERMS);

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [3:0]         a_q, a_d;
    logic [3:0]         b_q, b_d;
    logic               v1_q, v1_d;
    logic               ov_q, ov_d;
    logic [PROD_W-1:0]  prod;
    logic               xfer;

    top_a1_q2_array_multi_4bit u_mult (
        .a_i (a_q),
        .b_i (b_q),
        .p_o (prod)
    );

    // Handshake: ready in IDLE or while ACCUM still has pairs to take; clr
    // blocks acceptance, and reset forces the idle-looking outputs at once.
    always_comb begin
        in_ready = rst | (~clr & ((state_q == IDLE) |
                                  ((state_q == ACCUM) & (cnt_q < N_LAST))));
        xfer      = in_valid & in_ready & ~rst;
        out_valid = ov_q & ~rst;
        busy      = (state_q == ACCUM) & ~rst;
        Acc_out   = acc_q;
    end

    // Next-state: operand capture, accumulation, FSM sequencing and clr abort.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        v1_d    = xfer;
        ov_d    = ov_q;

        if (xfer) begin
            a_d   = A;
            b_d   = B;
            cnt_d = cnt_q + 5'd1;
        end

        if (v1_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                // All pairs accepted and the last one is being added now.
                if (v1_q && (cnt_q == N_LAST)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // One cycle after entering HOLD the result is presented;
                // it is cleared only on the consuming edge.
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = 5'd0;
                    ov_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = 5'd0;
            v1_d    = 1'b0;
            ov_d    = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            acc_q   <= '0;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            v1_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            v1_q    <= v1_d;
            ov_q    <= ov_d;
        end
    end

endmodule

// File: tb/tb_mac_accum_4bit.sv
// Scoreboard bench for mac_accum_4bit: four instances (N_TERMS 4, 16, 3, 1)
// share the operand bus; sel chooses which one is driven and observed.
module tb_mac_accum_4bit;

    logic        clk = 1'b0;
    logic        rst, clr, in_valid, out_ready;
    logic [3:0]  A, B;
    logic [1:0]  sel;

    logic [3:0]        in_ready_w, out_valid_w, busy_w;
    logic [3:0][11:0]  acc_w;

    logic        in_ready_m, out_valid_m, busy_m;
    logic [11:0] acc_m;

    typedef struct { int sum; int cyc; } exp_t;
    exp_t q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_xfer = 0;
    bit seen = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign in_ready_m  = in_ready_w[sel];
    assign out_valid_m = out_valid_w[sel];
    assign busy_m      = busy_w[sel];
    assign acc_m       = acc_w[sel];

    mac_accum_4bit #(.N_TERMS(4)) u_n4 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid && sel == 2'd0),
        .in_ready(in_ready_w[0]), .A(A), .B(B), .out_valid(out_valid_w[0]),
        .out_ready(out_ready && sel == 2'd0), .Acc_out(acc_w[0]), .busy(busy_w[0]));
    mac_accum_4bit #(.N_TERMS(16)) u_n16 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid && sel == 2'd1),
        .in_ready(in_ready_w[1]), .A(A), .B(B), .out_valid(out_valid_w[1]),
        .out_ready(out_ready && sel == 2'd1), .Acc_out(acc_w[1]), .busy(busy_w[1]));
    mac_accum_4bit #(.N_TERMS(3)) u_n3 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid && sel == 2'd2),
        .in_ready(in_ready_w[2]), .A(A), .B(B), .out_valid(out_valid_w[2]),
        .out_ready(out_ready && sel == 2'd2), .Acc_out(acc_w[2]), .busy(busy_w[2]));
    mac_accum_4bit #(.N_TERMS(1)) u_n1 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid && sel == 2'd3),
        .in_ready(in_ready_w[3]), .A(A), .B(B), .out_valid(out_valid_w[3]),
        .out_ready(out_ready && sel == 2'd3), .Acc_out(acc_w[3]), .busy(busy_w[3]));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: on each newly presented result, pop the expectation and compare
    // the sum and the edge on which it appeared.
    always @(posedge clk) begin
        #3;
        if (out_valid_m && !seen) begin
            seen = 1'b1;
            if (q.size() == 0) begin
                check("unexpected_result", int'(acc_m), -1);
            end else begin
                mon_e = q.pop_front();
                check("sum", int'(acc_m), mon_e.sum);
                check("latency", cyc, mon_e.cyc);
            end
        end
        if (!out_valid_m) seen = 1'b0;
    end

    task automatic send(input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        #1;
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready_m) begin
            check("xfer_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            last_xfer = cyc + 1;
            @(posedge clk);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic expect_res(input int sum);
        exp_t e;
        e.sum = sum;
        e.cyc = last_xfer + 2;
        q.push_back(e);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        @(negedge clk);
        while (!out_valid_m && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid_m) check("valid_timeout", 0, 1);
    endtask

    logic [3:0] s6_a [3];
    logic [3:0] s6_b [3];
    int model_sum, model_cnt;

    initial begin
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = 4'd0; B = 4'd0; sel = 2'd0;
        s6_a[0] = 4'd2; s6_b[0] = 4'd3;
        s6_a[1] = 4'd4; s6_b[1] = 4'd4;
        s6_a[2] = 4'd1; s6_b[2] = 4'd15;

        // Reset: during rst and the cycle after.
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", int'(in_ready_m), 1);
        check("rst_out_valid", int'(out_valid_m), 0);
        check("rst_busy", int'(busy_m), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_out_valid", int'(out_valid_m), 0);
        check("post_rst_acc", int'(acc_m), 0);
        check("post_rst_in_ready", int'(in_ready_m), 1);
        check("post_rst_busy", int'(busy_m), 0);

        // Scenario 1: four back-to-back pairs.
        sel = 2'd0;
        send(4'd3, 4'd5); send(4'd15, 4'd15); send(4'd0, 4'd9); send(4'd7, 4'd2);
        expect_res(254);
        idle(4);

        // Scenario 2: sixteen maximal products.
        sel = 2'd1; out_ready = 1'b0;
        repeat (16) send(4'd15, 4'd15);
        expect_res(3600);
        idle(1);
        #1;
        check("s2_ready_after_16", int'(in_ready_m), 0);
        wait_valid();
        #1;
        check("s2_ready_in_hold", int'(in_ready_m), 0);
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("s2_ready_after_consume", int'(in_ready_m), 1);
        check("s2_valid_after_consume", int'(out_valid_m), 0);

        // Scenario 3: back-pressure in HOLD, then a fresh sum.
        sel = 2'd0; out_ready = 1'b0;
        repeat (4) send(4'd1, 4'd2);
        expect_res(8);
        idle(1);
        wait_valid();
        repeat (5) begin
            @(negedge clk);
            #1;
            check("s3_hold_valid", int'(out_valid_m), 1);
            check("s3_hold_acc", int'(acc_m), 8);
            check("s3_hold_ready", int'(in_ready_m), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("s3_consumed_valid", int'(out_valid_m), 0);
        check("s3_consumed_ready", int'(in_ready_m), 1);
        check("s3_consumed_busy", int'(busy_m), 0);
        repeat (4) send(4'd2, 4'd2);
        expect_res(16);
        idle(4);

        // Scenario 4: clr after two pairs discards the partial sum.
        sel = 2'd0;
        send(4'd9, 4'd9); send(4'd9, 4'd9);
        @(negedge clk);
        clr = 1'b1; in_valid = 1'b1; A = 4'd5; B = 4'd5;
        #1;
        check("s4_ready_during_clr", int'(in_ready_m), 0);
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        #1;
        check("s4_busy_after_clr", int'(busy_m), 0);
        check("s4_acc_after_clr", int'(acc_m), 0);
        check("s4_ready_after_clr", int'(in_ready_m), 1);
        repeat (4) send(4'd1, 4'd1);
        expect_res(4);
        idle(4);

        // Scenario 5: reset while holding an unconsumed result.
        sel = 2'd0; out_ready = 1'b0;
        repeat (4) send(4'd3, 4'd3);
        expect_res(36);
        idle(1);
        wait_valid();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("s5_rst_ready", int'(in_ready_m), 1);
        check("s5_rst_valid", int'(out_valid_m), 0);
        check("s5_rst_busy", int'(busy_m), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("s5_post_valid", int'(out_valid_m), 0);
        check("s5_post_acc", int'(acc_m), 0);
        check("s5_post_ready", int'(in_ready_m), 1);
        check("s5_post_busy", int'(busy_m), 0);
        out_ready = 1'b1;

        // Scenario 6: in_valid every other cycle, N_TERMS=3.
        sel = 2'd2; model_sum = 0; model_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            send(s6_a[i], s6_b[i]);
            model_sum += int'(s6_a[i]) * int'(s6_b[i]);
            model_cnt++;
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            check("s6_busy_after_xfer", int'(busy_m), 1);
            check("s6_ready_after_xfer", int'(in_ready_m), (model_cnt < 3) ? 1 : 0);
        end
        check("s6_model_sum", model_sum, 37);
        expect_res(37);
        idle(4);

        // N_TERMS=1: each transfer is its own result.
        sel = 2'd3;
        send(4'd5, 4'd6);
        expect_res(30);
        idle(1);
        #1;
        check("n1_ready_after_xfer", int'(in_ready_m), 0);
        send(4'd15, 4'd15);
        expect_res(225);
        idle(6);

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        check("queue_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
